nibble_serial_subtractor: RTL and testbench

- Multi-cycle unsigned/signed subtractor computing diff = a − b as a + ~b + 1.
- Processes one 4-bit nibble per clock through a single 4-bit ripple slice, LSB nibble first.
- Provides ALU-style result flags with valid/ready handshakes on both input and output sides.
- Intended as a low-area arithmetic unit beside the combinational adder chain in the datapath.

---
 rtl/nibble_serial_subtractor_pkg.sv | 12 +
 rtl/nibble_serial_subtractor_slice.sv | 18 +
 rtl/nibble_serial_subtractor.sv | 133 +++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial subtractor.
package nss_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/nibble_serial_subtractor_slice.sv
// One 4-bit ripple step of a - b, computed as a + ~b + cin.
module nibble_sub_slice
  import nss_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_cout
);

  logic [NIBBLE_W:0] w_total;

  assign w_total = {1'b0, i_a} + {1'b0, ~i_b} + {{NIBBLE_W{1'b0}}, i_cin};
  assign o_sum   = w_total[NIBBLE_W-1:0];
  assign o_cout  = w_total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: one nibble per clock through a single slice, LSB first,
// with registered ALU flags and valid/ready handshakes on both sides.
module nibble_serial_subtractor
  import nss_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : gIllegalWidth
      $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_e                r_state;
  state_e                w_stateNext;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_carry;
  logic [WIDTH-1:0]      r_opA;
  logic [WIDTH-1:0]      r_opB;
  logic [WIDTH-1:0]      r_diff;
  logic [WIDTH-1:0]      w_diffNext;
  logic [WIDTH-1:0]      r_diffOut;
  logic                  r_borrow;
  logic                  r_overflow;
  logic                  r_zero;
  logic [NIBBLE_W-1:0]   w_aNib;
  logic [NIBBLE_W-1:0]   w_bNib;
  logic [NIBBLE_W-1:0]   w_sum;
  logic                  w_cout;
  logic                  w_lastNib;

  assign w_aNib    = r_opA[r_cnt*NIBBLE_W +: NIBBLE_W];
  assign w_bNib    = r_opB[r_cnt*NIBBLE_W +: NIBBLE_W];
  assign w_lastNib = (r_cnt == CNT_W'(NIB - 1));

  nibble_sub_slice uSlice (
    .i_a   (w_aNib),
    .i_b   (w_bNib),
    .i_cin (r_carry),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  always_comb begin
    w_diffNext = r_diff;
    w_diffNext[r_cnt*NIBBLE_W +: NIBBLE_W] = w_sum;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (valid_i) w_stateNext = BUSY;
      BUSY:    if (w_lastNib) w_stateNext = DONE;
      DONE:    if (ready_i) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Flags are taken from the final slice output on the same edge that enters DONE,
  // so the published result never passes through a partially built value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_opA      <= '0;
      r_opB      <= '0;
      r_diff     <= '0;
      r_diffOut  <= '0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_opA   <= a_i;
            r_opB   <= b_i;
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_diff  <= '0;
          end
        end
        BUSY: begin
          r_diff  <= w_diffNext;
          r_carry <= w_cout;
          r_cnt   <= w_lastNib ? '0 : r_cnt + 1'b1;
          if (w_lastNib) begin
            r_diffOut  <= w_diffNext;
            r_borrow   <= ~w_cout;
            r_overflow <= (r_opA[WIDTH-1] != r_opB[WIDTH-1]) &&
                          (w_diffNext[WIDTH-1] != r_opA[WIDTH-1]);
            r_zero     <= (w_diffNext == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready_o    = (r_state == IDLE);
  assign valid_o    = (r_state == DONE);
  assign diff_o     = r_diffOut;
  assign borrow_o   = r_borrow;
  assign overflow_o = r_overflow;
  assign zero_o     = r_zero;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed-vector bench for nibble_serial_subtractor at WIDTH=32 (8 nibble steps).
module tb_nibble_serial_subtractor;

  localparam int WIDTH = 32;
  localparam int NIB   = 8;

  logic             clk_i;
  logic             rst_ni;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] diff_o;
  logic             borrow_o;
  logic             overflow_o;
  logic             zero_o;

  int numChecks;
  int numFails;
  int waits;

  nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .diff_o    (diff_o),
    .borrow_o  (borrow_o),
    .overflow_o(overflow_o),
    .zero_o    (zero_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Single comparison point: every check is counted here and mismatches are reported.
  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents operands and returns once an edge has accepted them (bounded wait).
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               output int edges);
    logic wasReady;
    logic accepted;
    valid_i  = 1'b1;
    a_i      = a;
    b_i      = b;
    edges    = 0;
    accepted = 1'b0;
    for (int k = 0; k < 50 && !accepted; k++) begin
      wasReady = ready_o;
      @(posedge clk_i);
      #1;
      edges++;
      if (wasReady) accepted = 1'b1;
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Checks latency and the full result, starting just after the accepting edge.
  task automatic checkResult(input string tag, input logic [WIDTH-1:0] expDiff,
                             input logic expBorrow, input logic expOvf, input logic expZero);
    checkOutput({tag, "_ready_busy"}, 32'(ready_o), 32'd0);
    repeat (NIB - 1) @(posedge clk_i);
    #1;
    checkOutput({tag, "_valid_early"}, 32'(valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    checkOutput({tag, "_valid"}, 32'(valid_o), 32'd1);
    checkOutput({tag, "_diff"}, diff_o, expDiff);
    checkOutput({tag, "_borrow"}, 32'(borrow_o), 32'(expBorrow));
    checkOutput({tag, "_overflow"}, 32'(overflow_o), 32'(expOvf));
    checkOutput({tag, "_zero"}, 32'(zero_o), 32'(expZero));
    checkOutput({tag, "_ready_done"}, 32'(ready_o), 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] expDiff, input logic expBorrow,
                       input logic expOvf, input logic expZero);
    int edges;
    ready_i = 1'b1;
    applyStimulus(a, b, edges);
    valid_i = 1'b0;
    checkResult(tag, expDiff, expBorrow, expOvf, expZero);
    @(posedge clk_i);
    #1;
    checkOutput({tag, "_valid_after"}, 32'(valid_o), 32'd0);
    checkOutput({tag, "_ready_after"}, 32'(ready_o), 32'd1);
    checkOutput({tag, "_diff_hold"}, diff_o, expDiff);
  endtask

  initial begin
    numChecks = 0;
    numFails  = 0;
    rst_ni    = 1'b0;
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    a_i       = '0;
    b_i       = '0;

    #12;
    checkOutput("rst_ready", 32'(ready_o), 32'd1);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_diff", diff_o, 32'd0);
    checkOutput("rst_flags", {29'd0, borrow_o, overflow_o, zero_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    runOp("sub10_3", 32'd10, 32'd3, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
    runOp("sub3_10", 32'd3, 32'd10, 32'hFFFF_FFF9, 1'b1, 1'b0, 1'b0);
    runOp("minneg", 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    runOp("maxpos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    runOp("bzero", 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);

    // Equal operands with the consumer stalling; a new request must wait for IDLE.
    ready_i = 1'b0;
    applyStimulus(32'h1234_5678, 32'h1234_5678, waits);
    valid_i = 1'b0;
    checkResult("equal", 32'd0, 1'b0, 1'b0, 1'b1);
    valid_i = 1'b1;
    a_i     = 32'd1;
    b_i     = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      checkOutput("stall_valid", 32'(valid_o), 32'd1);
      checkOutput("stall_ready", 32'(ready_o), 32'd0);
      checkOutput("stall_diff", diff_o, 32'd0);
      checkOutput("stall_zero", 32'(zero_o), 32'd1);
    end
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("handshake_valid", 32'(valid_o), 32'd0);
    checkOutput("handshake_ready", 32'(ready_o), 32'd1);
    applyStimulus(32'd1, 32'd1, waits);
    checkOutput("late_accept_edges", 32'(waits), 32'd1);
    valid_i = 1'b0;
    checkResult("one_minus_one", 32'd0, 1'b0, 1'b0, 1'b1);

    // Back-to-back with valid_i held high: second pair taken one edge after handshake.
    applyStimulus(32'd100, 32'd58, waits);
    a_i = 32'd20;
    b_i = 32'd30;
    checkResult("b2b_first", 32'd42, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'd20, 32'd30, waits);
    checkOutput("b2b_accept_edges", 32'(waits), 32'd2);
    valid_i = 1'b0;
    checkResult("b2b_second", 32'hFFFF_FFF6, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset three cycles into a busy operation.
    applyStimulus(32'h0000_AAAA, 32'd1, waits);
    valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(valid_o), 32'd0);
    checkOutput("abort_ready", 32'(ready_o), 32'd1);
    checkOutput("abort_diff", diff_o, 32'd0);
    checkOutput("abort_flags", {29'd0, borrow_o, overflow_o, zero_o}, 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    checkOutput("release_ready", 32'(ready_o), 32'd1);
    runOp("after_reset", 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
